// File: rtl/sr_trace_tx_pkg.sv
// Shared constants and state encodings for the schoolRISCV trace transmitter.
// Frame length and record width follow SR_TRACE_CYCLE_EN (defined: 11-byte frame
// with a 16-bit capture timestamp; undefined: 9-byte frame of sync, pc, instr).
package sr_trace_tx_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef SR_TRACE_CYCLE_EN
  localparam int FRAME_BYTES = 11;
`else
  localparam int FRAME_BYTES = 9;
`endif

  // A record is everything in the frame after the sync byte.
  localparam int REC_W   = (FRAME_BYTES - 1) * 8;
  localparam int FRAME_W = FRAME_BYTES * 8;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} txState_t;
  typedef enum logic [1:0] {U_IDLE, START, DATA, STOP} uartState_t;

endpackage

// File: rtl/sr_uart_tx.sv
// Purpose: single-byte UART 8N1 serializer (start 0, data LSB first, stop 1).
// Latency: start bit appears on tx the cycle after start; byte = 10*CLK_PER_BIT cycles.
// Backpressure: start is honoured only while idle or in the done cycle; ignored otherwise.
// Ports: clk, rst (sync, active high), start/data (byte request), tx (line, idle high),
//        done (one-cycle pulse in the last cycle of the stop bit).
module sr_uart_tx
  import sr_trace_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

  uartState_t state, stateNext;
  logic [BW-1:0] baudCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shReg;
  logic          bitEnd;
  logic          accept;

  assign bitEnd = (baudCnt == BAUD_LAST);
  assign done   = (state == STOP) && bitEnd;
  // A new byte can be chained in the done cycle so bytes run with no idle bits.
  assign accept = start && ((state == U_IDLE) || done);

  always_comb begin
    stateNext = state;
    case (state)
      U_IDLE: if (start) stateNext = START;
      START:  if (bitEnd) stateNext = DATA;
      DATA:   if (bitEnd && (bitCnt == 3'd7)) stateNext = STOP;
      STOP:   if (bitEnd) stateNext = start ? START : U_IDLE;
      default: stateNext = U_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shReg[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= U_IDLE;
      baudCnt <= '0;
      bitCnt  <= '0;
      shReg   <= '0;
    end else begin
      state <= stateNext;
      // Baud counter wraps exactly at the end of every bit; held at 0 while idle.
      if ((state == U_IDLE) || bitEnd) baudCnt <= '0;
      else                             baudCnt <= baudCnt + 1'b1;
      if (accept) begin
        shReg <= data;
      end else if ((state == DATA) && bitEnd) begin
        shReg <= shReg >> 1;
      end
      // Bit counter wraps 7 -> 0 at the end of the last data bit.
      if ((state == DATA) && bitEnd) bitCnt <= bitCnt + 3'd1;
    end
  end

endmodule

// File: rtl/sr_trace_tx.sv
// Purpose: trace transmitter; buffers (pc, instr) per retired instruction, sends framed UART bytes.
// Latency: record written at edge N into an empty, idle unit drives the start bit after edge N+2.
// Backpressure: none upstream; a record arriving at a full FIFO is dropped and counted.
// Ports: clk, rst (sync, active high); trace_valid/trace_pc/trace_instr capture input;
//        tx UART line; busy = FIFO non-empty or frame in progress; overflow (sticky) and
//        drop_cnt (saturating) report drops, both zeroed by clr_ovf.
// Build option SR_TRACE_CYCLE_EN: adds a free-running 16-bit cycle stamp to every record.
module sr_trace_tx
  import sr_trace_tx_pkg::*;
#(
  parameter int         DEPTH       = 8,
  parameter int         CLK_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_instr,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  input  logic        clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr, rdPtr;
  logic             fifoEmpty, fifoFull;
  logic             push, drop, pop;
  logic [REC_W-1:0] rec;

  txState_t         state, stateNext;
  logic [FRAME_W-1:0] holder;
  logic [3:0]       byteIdx;
  logic             shiftHolder;
  logic             uStart, uDone;
  logic [7:0]       uData;

`ifdef SR_TRACE_CYCLE_EN
  logic [15:0] cycCnt;

  always_ff @(posedge clk) begin
    if (rst) cycCnt <= '0;
    else     cycCnt <= cycCnt + 16'd1;
  end

  assign rec = {cycCnt, trace_instr, trace_pc};
`else
  assign rec = {trace_instr, trace_pc};
`endif

  // Extra pointer bit separates full from empty when the index bits match.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  // Fullness is taken before any pop in the same cycle.
  assign push = trace_valid && !fifoFull;
  assign drop = trace_valid && fifoFull;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_comb begin
    stateNext   = state;
    pop         = 1'b0;
    shiftHolder = 1'b0;
    uStart      = 1'b0;
    uData       = holder[15:8];
    case (state)
      IDLE: if (!fifoEmpty) stateNext = LOAD;
      LOAD: begin
        pop       = 1'b1;
        uStart    = 1'b1;
        uData     = SYNC_BYTE;
        stateNext = SEND;
      end
      SEND: begin
        if (uDone) begin
          if (byteIdx == LAST_BYTE) begin
            if (!fifoEmpty) begin
              // Chain the next frame straight from the final done cycle so the
              // line carries no idle bit between consecutive frames.
              pop    = 1'b1;
              uStart = 1'b1;
              uData  = SYNC_BYTE;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            shiftHolder = 1'b1;
            uStart      = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      holder  <= '0;
      byteIdx <= '0;
    end else begin
      state <= stateNext;
      if (pop) begin
        // Byte k of the frame sits in holder[8k+7:8k]; shifting moves the next byte to [15:8].
        holder  <= {mem[rdPtr[AW-1:0]], SYNC_BYTE};
        byteIdx <= '0;
      end else if (shiftHolder) begin
        holder  <= holder >> 8;
        byteIdx <= byteIdx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign busy = !fifoEmpty || (state != IDLE);

  sr_uart_tx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) uUart (
    .clk  (clk),
    .rst  (rst),
    .start(uStart),
    .data (uData),
    .tx   (tx),
    .done (uDone)
  );

endmodule
